// File: rtl/line_mem_arbiter_pkg.sv
// Shared types and constants for the I/D line-memory arbiter.
package line_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    typedef enum logic {
        CLIENT_I = 1'b0,
        CLIENT_D = 1'b1
    } arb_client_t;

    localparam int LINE_OFFSET = 5;

endpackage

// File: rtl/line_mem_arbiter.sv
// Arbitrates I-cache and D-cache line misses onto one physical-memory line port.
// Optional ARB_ROUND_ROBIN_EN replaces fixed D-over-I priority with alternation.
module line_mem_arbiter
    import line_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output arb_state_t        dbg_state
);

    localparam logic [ADDR_W-1:0] ADDR_MASK =
        {{(ADDR_W-LINE_OFFSET){1'b1}}, {LINE_OFFSET{1'b0}}};

    // Handshake: a client holds read/write high until its one-cycle resp pulse and
    // drops it in the following (DONE) cycle; memory strobes likewise hold until pmem_resp.

    arb_state_t          state;
    logic [ADDR_W-1:0]   lat_addr;
    logic [LINE_W-1:0]   lat_wdata;
    logic                lat_write;
    logic                i_pend;
    logic                d_pend;
    arb_client_t         winner;
`ifdef ARB_ROUND_ROBIN_EN
    arb_client_t         last_grant;
`endif

    assign i_pend = i_read;
    assign d_pend = d_read | d_write;

    always_comb begin
        winner = CLIENT_I;
`ifdef ARB_ROUND_ROBIN_EN
        if (i_pend && d_pend)
            winner = (last_grant == CLIENT_I) ? CLIENT_D : CLIENT_I;
        else if (d_pend)
            winner = CLIENT_D;
`else
        if (d_pend)
            winner = CLIENT_D;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_write <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= CLIENT_I;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_pend || d_pend) begin
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant <= winner;
`endif
                        if (winner == CLIENT_D) begin
                            state     <= SERVE_D;
                            lat_addr  <= d_address & ADDR_MASK;
                            lat_wdata <= d_wdata;
                            lat_write <= d_write;
                        end else begin
                            state     <= SERVE_I;
                            lat_addr  <= i_address & ADDR_MASK;
                            lat_write <= 1'b0;
                        end
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (pmem_resp)
                        state <= DONE;
                end
                // Dead cycle lets the client drop its request before re-arbitration.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes decode registered state only, so reset clears them immediately.
    assign pmem_read    = (state == SERVE_I) || ((state == SERVE_D) && !lat_write);
    assign pmem_write   = (state == SERVE_D) && lat_write;
    assign pmem_address = lat_addr;
    assign pmem_wdata   = lat_wdata;

    assign i_resp  = (state == SERVE_I) && pmem_resp;
    assign d_resp  = (state == SERVE_D) && pmem_resp;
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

    assign dbg_state = state;

endmodule
